// File: rtl/dm_cache_controller.sv
// dm_cache_controller: direct-mapped, write-back, write-allocate cache between a
// 32-bit word processor port and a 128-bit block memory port.
//
// Ports
//   clk, proc_reset        : clock, synchronous active-high reset
//   proc_read, proc_write  : processor requests (level, held while stalled; read wins)
//   proc_addr[29:0]        : word address {tag[24:0], index[2:0], offset[1:0]}
//   proc_wdata, proc_rdata : processor write / read data (rdata combinational)
//   proc_stall             : combinational stall, high while a request is unsatisfied
//   mem_read, mem_write    : registered block transfer requests (never both high)
//   mem_addr[27:0]         : registered block address {tag, index}
//   mem_wdata, mem_rdata   : victim block out / fill block in (word 0 in [31:0])
//   mem_ready              : one-cycle completion pulse from memory
module dm_cache_controller #(
   parameter int unsigned LINES   = 8,
   parameter int unsigned WORD_W  = 32,
   parameter int unsigned BLOCK_W = 128
) (
   input  logic               clk,
   input  logic               proc_reset,
   input  logic               proc_read,
   input  logic               proc_write,
   input  logic [29:0]        proc_addr,
   input  logic [WORD_W-1:0]  proc_wdata,
   output logic [WORD_W-1:0]  proc_rdata,
   output logic               proc_stall,
   output logic               mem_read,
   output logic               mem_write,
   output logic [27:0]        mem_addr,
   output logic [BLOCK_W-1:0] mem_wdata,
   input  logic [BLOCK_W-1:0] mem_rdata,
   input  logic               mem_ready
);

   localparam int unsigned ADDR_W = 30;
   localparam int unsigned WORDS  = BLOCK_W / WORD_W;
   localparam int unsigned OFF_W  = $clog2(WORDS);
   localparam int unsigned IDX_W  = $clog2(LINES);
   localparam int unsigned TAG_W  = ADDR_W - OFF_W - IDX_W;

   typedef enum logic [1:0] {
      S_COMPARE,
      S_WRITEBACK,
      S_ALLOCATE
   } state_t;

   state_t               state;
   logic [LINES-1:0]     valid_q;
   logic [LINES-1:0]     dirty_q;
   logic [TAG_W-1:0]     tag_q  [LINES];
   logic [BLOCK_W-1:0]   data_q [LINES];

   logic [IDX_W-1:0]     idx;
   logic [TAG_W-1:0]     tag;
   logic [OFF_W-1:0]     off;
   logic                 hit;
   logic                 req;
   logic                 do_write;
   logic [WORD_W-1:0]    sel_word;
   logic [BLOCK_W-1:0]   merged;

   assign idx      = proc_addr[OFF_W +: IDX_W];
   assign tag      = proc_addr[ADDR_W-1 -: TAG_W];
   assign off      = proc_addr[OFF_W-1:0];
   assign hit      = valid_q[idx] && (tag_q[idx] == tag);
   assign req      = proc_read | proc_write;
   assign do_write = proc_write & ~proc_read;

   // Word select for reads and word merge for write hits on the addressed line
   always_comb begin
      sel_word = '0;
      merged   = data_q[idx];
      for (int unsigned w = 0; w < WORDS; w++) begin
         if (off == OFF_W'(w)) begin
            sel_word                    = data_q[idx][w*WORD_W +: WORD_W];
            merged[w*WORD_W +: WORD_W]  = proc_wdata;
         end
      end
   end

   // Processor-side combinational outputs; rdata is zero unless a read hits
   always_comb begin
      proc_stall = 1'b0;
      proc_rdata = '0;
      case (state)
         S_COMPARE: begin
            proc_stall = req & ~hit;
            if (proc_read && hit) proc_rdata = sel_word;
         end
         default: proc_stall = 1'b1;
      endcase
   end

   // Controller FSM with registered memory-side outputs and line status bits
   always_ff @(posedge clk) begin
      if (proc_reset) begin
         state     <= S_COMPARE;
         valid_q   <= '0;
         dirty_q   <= '0;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         case (state)
            S_COMPARE: begin
               if (req) begin
                  if (hit) begin
                     if (do_write) dirty_q[idx] <= 1'b1;
                  end else if (valid_q[idx] && dirty_q[idx]) begin
                     state     <= S_WRITEBACK;
                     mem_write <= 1'b1;
                     mem_read  <= 1'b0;
                     mem_addr  <= {tag_q[idx], idx};
                     mem_wdata <= data_q[idx];
                  end else begin
                     state     <= S_ALLOCATE;
                     mem_read  <= 1'b1;
                     mem_write <= 1'b0;
                     mem_addr  <= proc_addr[ADDR_W-1:OFF_W];
                  end
               end
            end
            S_WRITEBACK: begin
               // Fill request follows the writeback completion with no idle cycle
               if (mem_ready) begin
                  state     <= S_ALLOCATE;
                  mem_write <= 1'b0;
                  mem_read  <= 1'b1;
                  mem_addr  <= proc_addr[ADDR_W-1:OFF_W];
               end
            end
            S_ALLOCATE: begin
               // Drop the request on the same edge that sees ready so memory
               // does not start a second transaction
               if (mem_ready) begin
                  state        <= S_COMPARE;
                  valid_q[idx] <= 1'b1;
                  dirty_q[idx] <= 1'b0;
                  mem_read     <= 1'b0;
               end
            end
            default: state <= S_COMPARE;
         endcase
      end
   end

   // Tag and data arrays carry no reset; valid_q qualifies their contents
   always_ff @(posedge clk) begin
      if (!proc_reset) begin
         if (state == S_COMPARE && do_write && hit) begin
            data_q[idx] <= merged;
         end else if (state == S_ALLOCATE && mem_ready) begin
            data_q[idx] <= mem_rdata;
            tag_q[idx]  <= tag;
         end
      end
   end

endmodule

// File: tb/tb_dm_cache_controller.sv
// Testbench for dm_cache_controller: directed traffic, a block-memory responder,
// and a transparent-memory reference model checked on every meaningful cycle.
module tb_dm_cache_controller;

   logic         clk;
   logic         proc_reset;
   logic         proc_read;
   logic         proc_write;
   logic [29:0]  proc_addr;
   logic [31:0]  proc_wdata;
   logic [31:0]  proc_rdata;
   logic         proc_stall;
   logic         mem_read;
   logic         mem_write;
   logic [27:0]  mem_addr;
   logic [127:0] mem_wdata;
   logic [127:0] mem_rdata;
   logic         mem_ready;

   dm_cache_controller dut (
      .clk        (clk),
      .proc_reset (proc_reset),
      .proc_read  (proc_read),
      .proc_write (proc_write),
      .proc_addr  (proc_addr),
      .proc_wdata (proc_wdata),
      .proc_rdata (proc_rdata),
      .proc_stall (proc_stall),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Backing memory contents and processor writes not yet lost to a reset
   logic [127:0] mem_model [logic [27:0]];
   logic [31:0]  overlay   [logic [29:0]];

   // Responder state
   int           lat = 3;
   bit           busy = 0;
   int           cnt = 0;
   bit           cur_wr = 0;
   logic [27:0]  cur_addr = '0;
   logic [127:0] cur_data = '0;
   bit           abandoned = 0;
   bit           exp_next_rd = 0;
   bit           spurious_req = 0;
   int           rd_cnt = 0;
   int           wr_cnt = 0;
   logic [27:0]  last_rd_addr = '0;
   logic [27:0]  last_wr_addr = '0;
   logic [127:0] last_wr_data = '0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [127:0] mem_get(input logic [27:0] b);
      logic [127:0] blk;
      if (mem_model.exists(b)) return mem_model[b];
      for (int w = 0; w < 4; w++)
         blk[w*32 +: 32] = 32'hA000_0000 | (32'(b) << 4) | 32'(w);
      return blk;
   endfunction

   function automatic logic [31:0] exp_word(input logic [29:0] a);
      logic [127:0] blk;
      if (overlay.exists(a)) return overlay[a];
      blk = mem_get(a[29:2]);
      return blk[32'(a[1:0])*32 +: 32];
   endfunction

   // Block memory responder: fixed latency, one-cycle ready pulse
   always begin
      @(negedge clk);
      #1;
      if (mem_ready) begin
         mem_ready = 1'b0;
         mem_rdata = {$urandom, $urandom, $urandom, $urandom};
         chk("req_after_ready_rd", 128'(mem_read), 128'(exp_next_rd));
         chk("req_after_ready_wr", 128'(mem_write), 128'(0));
      end
      if (busy) begin
         if (proc_reset) abandoned = 1;
         if (cnt == 0) begin
            busy      = 0;
            mem_ready = 1'b1;
            if (cur_wr) begin
               mem_model[cur_addr] = cur_data;
               mem_rdata = {$urandom, $urandom, $urandom, $urandom};
            end else begin
               mem_rdata = mem_get(cur_addr);
            end
            exp_next_rd = cur_wr && !abandoned && !proc_reset;
         end else begin
            cnt--;
         end
      end else if (spurious_req) begin
         spurious_req = 0;
         mem_ready    = 1'b1;
         mem_rdata    = {$urandom, $urandom, $urandom, $urandom};
         exp_next_rd  = 0;
      end else if (!proc_reset && (mem_read || mem_write)) begin
         busy      = 1;
         cnt       = lat - 1;
         abandoned = 0;
         cur_wr    = mem_write;
         cur_addr  = mem_addr;
         cur_data  = mem_wdata;
         if (mem_write) begin
            logic [127:0] gold;
            wr_cnt++;
            last_wr_addr = mem_addr;
            last_wr_data = mem_wdata;
            for (int w = 0; w < 4; w++)
               gold[w*32 +: 32] = exp_word({mem_addr, 2'(w)});
            chk("wb_data_model", mem_wdata, gold);
            chk("wb_index", 128'(mem_addr[2:0]), 128'(proc_addr[4:2]));
            checks++;
            if (mem_addr == proc_addr[29:2]) begin
               errors++;
               $display("FAIL wb_tag: victim address %h equals requested block", mem_addr);
            end
         end else begin
            rd_cnt++;
            last_rd_addr = mem_addr;
            chk("fill_addr_model", 128'(mem_addr), 128'(proc_addr[29:2]));
         end
      end
   end

   // Compare process: reads against the transparent-memory model, idle stall, exclusivity
   always begin
      @(negedge clk);
      #2;
      if (proc_reset) begin
         overlay.delete();
      end else begin
         chk("rd_wr_exclusive", 128'(mem_read && mem_write), 128'(0));
         if (!proc_read && !proc_write)
            chk("idle_stall", 128'(proc_stall), 128'(0));
         if (proc_read && !proc_stall)
            chk("model_rdata", 128'(proc_rdata), 128'(exp_word(proc_addr)));
         else if (proc_write && !proc_stall)
            overlay[proc_addr] = proc_wdata;
      end
   end

   task automatic access(input bit rd, input logic [29:0] a, input logic [31:0] wd,
                         input int exp_stall, input bit chk_rd, input logic [31:0] exp_rd);
      int n;
      @(negedge clk);
      proc_read  = rd;
      proc_write = !rd;
      proc_addr  = a;
      proc_wdata = wd;
      #1;
      n = 0;
      while (proc_stall && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("stall_cycles", 128'(n), 128'(exp_stall));
      if (chk_rd) chk("rdata", 128'(proc_rdata), 128'(exp_rd));
      @(posedge clk);
      @(negedge clk);
      proc_read  = 1'b0;
      proc_write = 1'b0;
   endtask

   task automatic do_reset(input int cycles);
      @(negedge clk);
      proc_read  = 1'b0;
      proc_write = 1'b0;
      proc_reset = 1'b1;
      repeat (cycles) @(negedge clk);
      proc_reset = 1'b0;
   endtask

   task automatic wait_idle_no_req(input string name);
      int n;
      n = 0;
      while ((busy || mem_ready) && n < 100) begin
         @(posedge clk);
         #1;
         chk(name, 128'({mem_read, mem_write}), 128'(0));
         n++;
      end
      if (n >= 100) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: responder still busy after %0d cycles", name, n);
      end
      repeat (2) begin
         @(posedge clk);
         #1;
         chk(name, 128'({mem_read, mem_write}), 128'(0));
      end
   endtask

   initial begin
      proc_reset = 1'b1;
      proc_read  = 1'b0;
      proc_write = 1'b0;
      proc_addr  = '0;
      proc_wdata = '0;
      mem_rdata  = '0;
      mem_ready  = 1'b0;
      mem_model[28'h0] = {32'h33, 32'h22, 32'h11, 32'h00};

      // 1. Reset state, then a read that starts a fill, abandoned by reset
      repeat (2) @(negedge clk);
      proc_reset = 1'b0;
      #1;
      chk("rst_mem_read", 128'(mem_read), 128'(0));
      chk("rst_mem_write", 128'(mem_write), 128'(0));
      chk("rst_mem_addr", 128'(mem_addr), 128'(0));
      chk("rst_mem_wdata", mem_wdata, 128'(0));
      chk("rst_stall", 128'(proc_stall), 128'(0));
      chk("rst_rdata", 128'(proc_rdata), 128'(0));
      @(negedge clk);
      proc_read = 1'b1;
      proc_addr = 30'h0;
      #1;
      chk("miss_stall", 128'(proc_stall), 128'(1));
      @(posedge clk);
      #1;
      chk("miss_mem_read", 128'(mem_read), 128'(1));
      chk("miss_mem_write", 128'(mem_write), 128'(0));
      chk("miss_mem_addr", 128'(mem_addr), 128'(0));
      @(negedge clk);
      do_reset(2);
      wait_idle_no_req("abandon1_no_req");

      // 2. Clean read miss, then hits on the rest of the block
      lat = 3;
      access(1, 30'h2, 32'h0, 5, 1, 32'h22);
      access(1, 30'h0, 32'h0, 0, 1, 32'h00);
      access(1, 30'h1, 32'h0, 0, 1, 32'h11);
      access(1, 30'h3, 32'h0, 0, 1, 32'h33);

      // 3. Write hit, readback, read-over-write priority
      begin
         int r0, w0;
         r0 = rd_cnt;
         w0 = wr_cnt;
         access(0, 30'h1, 32'hDEADBEEF, 0, 0, 32'h0);
         chk("wrhit_no_mem", 128'({rd_cnt - r0, wr_cnt - w0}), 128'(0));
      end
      access(1, 30'h1, 32'h0, 0, 1, 32'hDEADBEEF);
      @(negedge clk);
      proc_read  = 1'b1;
      proc_write = 1'b1;
      proc_addr  = 30'h1;
      proc_wdata = 32'h1234_5678;
      #1;
      chk("prio_rdata", 128'(proc_rdata), 128'(32'hDEADBEEF));
      @(negedge clk);
      proc_read  = 1'b0;
      proc_write = 1'b0;
      access(1, 30'h1, 32'h0, 0, 1, 32'hDEADBEEF);

      // 4. Dirty conflict miss on index 0
      access(1, 30'h20, 32'h0, 9, 1, 32'hA000_0080);
      chk("dirty_wb_addr", 128'(last_wr_addr), 128'(28'h0));
      chk("dirty_wb_data", last_wr_data, {32'h33, 32'h22, 32'hDEADBEEF, 32'h00});
      chk("dirty_fill_addr", 128'(last_rd_addr), 128'(28'h8));

      // 5. Write miss allocate on a clean line, later evicted
      begin
         int r0, w0;
         r0 = rd_cnt;
         w0 = wr_cnt;
         access(0, 30'h45, 32'h5A, 5, 0, 32'h0);
         chk("wmiss_one_read", 128'(rd_cnt - r0), 128'(1));
         chk("wmiss_no_write", 128'(wr_cnt - w0), 128'(0));
         chk("wmiss_fill_addr", 128'(last_rd_addr), 128'(28'h11));
      end
      access(1, 30'h45, 32'h0, 0, 1, 32'h5A);
      access(1, 30'h65, 32'h0, 9, 1, 32'hA000_0191);
      chk("evict_wb_addr", 128'(last_wr_addr), 128'(28'h11));
      chk("evict_wb_word1", 128'(last_wr_data[63:32]), 128'(32'h5A));
      chk("evict_wb_word0", 128'(last_wr_data[31:0]), 128'(32'hA000_0110));

      // 6. Reset during ALLOCATE with a late ready, then a spurious ready in COMPARE
      lat = 6;
      @(negedge clk);
      proc_read = 1'b1;
      proc_addr = 30'h85;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("alloc_mem_read", 128'(mem_read), 128'(1));
      do_reset(2);
      wait_idle_no_req("abandon2_no_req");
      lat = 3;
      access(1, 30'h65, 32'h0, 5, 1, 32'hA000_0191);
      @(negedge clk);
      spurious_req = 1;
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("spurious_no_req", 128'({mem_read, mem_write}), 128'(0));
         chk("spurious_stall", 128'(proc_stall), 128'(0));
      end
      access(1, 30'h65, 32'h0, 0, 1, 32'hA000_0191);
      access(1, 30'h45, 32'h0, 5, 1, 32'h5A);

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

endmodule
